lsu_mem_stage: RTL and testbench
================================

# lsu_mem_stage

Load/store unit for the MEM stage of the RISC-V pipeline, sitting directly upstream of the word-addressed data memory. It takes byte-addressed load/store requests from the EX/MEM register and drives the data memory's word address, write data and write enable. Sub-word stores become single-cycle read-modify-writes, and accesses that span two words are split over two cycles with a pipeline stall. Loads return an aligned, sign- or zero-extended result to writeback through a registered response port.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words in data memory; word index >= DEPTH_WORDS is an access fault.
- MISALIGN_EN, 1: 1 = split word-spanning accesses; 0 = treat them as faults.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present from EX/MEM.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code:
  - 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
  - 3, 6 and 7 are illegal, as are 4 and 5 with req_we=1.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_rd  in  5  load destination register.
- stall  out  1  combinational; upstream holds all req_* inputs stable while high.
- mem_addr  out  32  word index to data memory.
- mem_wdata  out  32  merged word to data memory.
- mem_we  out  1  data memory write enable (1 = write).
- mem_rdata  in  32  combinational read data for mem_addr.
- resp_valid  out  1  registered; load result valid.
- resp_data  out  32  extended load data.
- resp_rd  out  5  destination register of the load.
- resp_fault  out  1  registered; one-cycle pulse per faulted request.

## Operation
- Address fields:
  - off = req_addr[1:0], w0 = req_addr[31:2], w1 = w0 + 1 (32-bit wrap).
  - size = 1/2/4 bytes for funct3 0/4, 1/5, 2.
- Split condition: off + size > 4.
  - Halfword splits only at off=3; a word splits at off 1..3; a byte never splits.
- Fault conditions: illegal funct3; w0 >= DEPTH_WORDS; a split access with w1 >= DEPTH_WORDS; a split access with MISALIGN_EN=0.
  - A faulted request makes no memory access (mem_we=0), retires in one cycle and never asserts stall.
- FSM states IDLE and SECOND; reset enters IDLE.
- IDLE with req_valid and no split (or fault):
  - mem_addr=w0; the request retires at this edge.
- IDLE with req_valid and split:
  - stall=1, mem_addr=w0.
  - Capture mem_rdata into lo_word and move to SECOND.
- SECOND:
  - stall=0, mem_addr=w1; the request retires at this edge and the FSM returns to IDLE.
- Store merge (little-endian):
  - Form the 64-bit value {w1 data, w0 data} from mem_rdata and lo_word.
  - Replace bytes off..off+size-1 with req_wdata bytes 0..size-1.
  - mem_wdata is the half that belongs to the current mem_addr; mem_we=1 on every non-faulted store cycle.
  - Bytes outside the access are written back unchanged.
- Load assembly:
  - Unsplit: mem_rdata >> 8*off.
  - Split: {mem_rdata, lo_word} >> 8*off.
  - Keep the low size bytes; sign-extend for funct3 0/1/2, zero-extend for 4/5.
- Idle outputs (no req_valid): mem_we=0, mem_addr=0, mem_wdata=0.

## Timing
- Reset values: state IDLE, lo_word 0, resp_valid 0, resp_data 0, resp_rd 0, resp_fault 0.
- While rst_n=0: mem_we=0 and mem_addr=0 combinationally, stall=0.
- Reset during SECOND abandons the request. The first word of a split store may already be written; that is accepted.
- Latency:
  - Unsplit load: resp_valid high the cycle after acceptance, 1 cycle.
  - Split load: resp_valid high the cycle after SECOND, 2 cycles, stall high for 1 cycle.
- resp_valid and resp_fault are single-cycle pulses.
  - resp_data and resp_rd hold their values until the next load retires.
  - resp_valid is never asserted for stores.
- Back-to-back requests are accepted every cycle when none split.
- A request presented in the cycle after SECOND is a new request.
- req_valid dropping while stall=1 is a protocol violation; behaviour is undefined.

## Test plan
- Aligned word: preload word 5 = 0x8899AABB; LW addr 0x14 -> resp_valid 1 cycle later, resp_data 0x8899AABB; no stall.
- Sub-word store: word 5 = 0x11223344; SB addr 0x15 data 0xFF -> word 5 = 0x1122FF44 after 1 cycle; LB addr 0x15 -> 0xFFFFFFFF; LBU addr 0x15 -> 0x000000FF.
- Split halfword load: word 2 = 0xAB000000, word 3 = 0x000000CD; LH addr 0x0B -> stall high 1 cycle, resp_data 0xFFFFCDAB 2 cycles after acceptance.
- Split word store: words 6 and 7 = 0; SW addr 0x1A data 0xDEADBEEF -> word 6 = 0xBEEF0000, word 7 = 0x0000DEAD; stall high exactly 1 cycle.
- Faults:
  - LW addr 0x400 (DEPTH 256) -> resp_fault pulse, mem_we never high, stall 0.
  - funct3=3 -> resp_fault.
  - With MISALIGN_EN=0, LW addr 0x01 -> resp_fault.
- Reset mid-operation: assert rst_n=0 during SECOND of a split load -> next cycle state IDLE, resp_valid 0, mem_we 0; a following LW completes normally.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM-stage load/store unit in front of a word-addressed data
// memory. It turns byte-addressed loads and stores into word accesses:
//   - Sub-word stores become single-cycle read-modify-writes.
//   - Accesses that span two words are split over two cycles, with a stall.
//   - Load results are returned sign- or zero-extended on a registered port.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   req_valid, req_we    request present / store (1) or load (0)
//   req_funct3           RV32I width code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr, req_wdata  byte address, right-aligned store data
//   req_rd               load destination register
//   stall                combinational; upstream holds req_* while high
//   mem_addr             word index to data memory
//   mem_wdata, mem_we    merged write word and write enable
//   mem_rdata            combinational read data for mem_addr
//   resp_valid           registered load-result pulse
//   resp_data, resp_rd   extended load data and its destination register
//   resp_fault           registered one-cycle pulse per faulted request
module lsu_mem_stage #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter bit          MISALIGN_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_fault
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SECOND = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] lo_word_q, lo_word_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [4:0]  resp_rd_q, resp_rd_d;
  logic        resp_fault_q, resp_fault_d;

  // Overwrite bytes off..off+size-1 of the two-word window with the low
  // store-data bytes; everything else is written back unchanged.
  function automatic logic [63:0] merge_store(input logic [63:0] base,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  off,
                                              input logic [2:0]  size);
    logic [63:0] r;
    r = base;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(size)) r[8*(int'(off)+i) +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

  // Align the window to the addressed byte, then sign/zero-extend.
  function automatic logic [31:0] extend_load(input logic [63:0] base,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [31:0]        sh;
    logic signed [7:0]  sb;
    logic signed [15:0] shw;
    sh  = 32'(base >> {off, 3'b000});
    sb  = sh[7:0];
    shw = sh[15:0];
    case (f3)
      3'd0:    return 32'(sb);
      3'd1:    return 32'(shw);
      3'd4:    return {24'h0, sh[7:0]};
      3'd5:    return {16'h0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  logic [1:0]  off;
  logic [31:0] w0_ext, w1_ext;
  logic [2:0]  size;
  logic        legal, split, fault;
  logic [63:0] window, merged;
  logic [31:0] load_val;

  assign off    = req_addr[1:0];
  assign w0_ext = {2'b00, req_addr[31:2]};
  assign w1_ext = w0_ext + 32'd1;

  always_comb begin
    size  = 3'd1;
    legal = 1'b0;
    case (req_funct3)
      3'd0: begin size = 3'd1; legal = 1'b1;    end
      3'd1: begin size = 3'd2; legal = 1'b1;    end
      3'd2: begin size = 3'd4; legal = 1'b1;    end
      3'd4: begin size = 3'd1; legal = !req_we; end
      3'd5: begin size = 3'd2; legal = !req_we; end
      default: begin size = 3'd1; legal = 1'b0; end
    endcase
  end

  assign split = ({1'b0, off} + size) > 3'd4;
  assign fault = !legal
              || (w0_ext >= 32'(DEPTH_WORDS))
              || (split && (w1_ext >= 32'(DEPTH_WORDS)))
              || (split && !MISALIGN_EN);

  // In SECOND the window is {second word, captured first word}; otherwise the
  // addressed word alone sits in the low half.
  assign window   = (state_q == S_SECOND) ? {mem_rdata, lo_word_q} : {32'h0, mem_rdata};
  assign merged   = merge_store(window, req_wdata, off, size);
  assign load_val = extend_load(window, off, req_funct3);

  always_comb begin
    stall        = 1'b0;
    mem_addr     = 32'h0;
    mem_wdata    = 32'h0;
    mem_we       = 1'b0;
    state_d      = state_q;
    lo_word_d    = lo_word_q;
    resp_valid_d = 1'b0;
    resp_fault_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_rd_d    = resp_rd_q;
    if (rst_n) begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            mem_addr = w0_ext;
            if (fault) begin
              resp_fault_d = 1'b1;
            end else begin
              mem_we    = req_we;
              mem_wdata = req_we ? merged[31:0] : 32'h0;
              if (split) begin
                // First word is written now (stores) and remembered so the
                // second cycle can assemble or merge across the boundary.
                stall     = 1'b1;
                lo_word_d = mem_rdata;
                state_d   = S_SECOND;
              end else if (!req_we) begin
                resp_valid_d = 1'b1;
                resp_data_d  = load_val;
                resp_rd_d    = req_rd;
              end
            end
          end
        end
        S_SECOND: begin
          mem_addr  = w1_ext;
          mem_we    = req_we;
          mem_wdata = req_we ? merged[63:32] : 32'h0;
          state_d   = S_IDLE;
          if (!req_we) begin
            resp_valid_d = 1'b1;
            resp_data_d  = load_val;
            resp_rd_d    = req_rd;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      lo_word_q    <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_rd_q    <= 5'd0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lo_word_q    <= lo_word_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_rd_q    <= resp_rd_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_rd    = resp_rd_q;
  assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: a byte-array reference model predicts every
// cycle's stall/memory-control/response values, checked once per cycle at
// the falling edge, plus literal expectations from hand-worked vectors.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        stall, mem_we, resp_valid, resp_fault;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, resp_data;
  logic [4:0]  resp_rd;

  // Second instance with MISALIGN_EN=0; its memory always reads zero.
  logic        stall2, mem_we2, resp_valid2, resp_fault2;
  logic [31:0] mem_addr2, mem_wdata2, resp_data2;
  logic [4:0]  resp_rd2;

  always #5 clk = ~clk;

  lsu_mem_stage #(.DEPTH_WORDS(256), .MISALIGN_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_rd(resp_rd), .resp_fault(resp_fault));

  lsu_mem_stage #(.DEPTH_WORDS(256), .MISALIGN_EN(1'b0)) dut_nomis (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .stall(stall2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_we(mem_we2), .mem_rdata(32'h0), .resp_valid(resp_valid2),
    .resp_data(resp_data2), .resp_rd(resp_rd2), .resp_fault(resp_fault2));

  // Data memory seen by the DUT.
  logic [31:0] mem_tb [0:255];
  logic        clr, pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;

  assign mem_rdata = (mem_addr < 32'd256) ? mem_tb[mem_addr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem_tb[i] <= 32'h0;
    end else if (pl_en) begin
      mem_tb[pl_idx] <= pl_data;
    end else if (mem_we && mem_addr < 32'd256) begin
      mem_tb[mem_addr[7:0]] <= mem_wdata;
    end
  end

  // Reference model state.
  logic [7:0]  ref_bytes [0:1023];
  logic        exp_stall, exp_we, exp_valid, exp_fault;
  logic [31:0] exp_addr, exp_data;
  logic [4:0]  exp_rd;
  logic        chk_en;
  int          total, bad, stall_cnt, s0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic compare_cycle();
    check("stall",      32'(stall),      32'(exp_stall));
    check("mem_we",     32'(mem_we),     32'(exp_we));
    check("mem_addr",   mem_addr,        exp_addr);
    check("resp_valid", 32'(resp_valid), 32'(exp_valid));
    check("resp_fault", 32'(resp_fault), 32'(exp_fault));
    check("resp_data",  resp_data,       exp_data);
    check("resp_rd",    32'(resp_rd),    32'(exp_rd));
  endtask

  // One clock cycle: compare at the falling edge, then step past the rising
  // edge; single-cycle pulses are cleared unless the caller re-asserts them.
  task automatic tick();
    @(negedge clk);
    if (chk_en) compare_cycle();
    if (stall) stall_cnt++;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    exp_fault = 1'b0;
  endtask

  task automatic preload(input int w, input logic [31:0] v);
    pl_en = 1'b1; pl_idx = 8'(w); pl_data = v;
    for (int k = 0; k < 4; k++) ref_bytes[4*w+k] = v[8*k +: 8];
    tick();
    pl_en = 1'b0;
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'd2) return 4;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
    logic [31:0] v;
    int sz;
    sz = size_of(f3);
    v = 32'h0;
    for (int k = 0; k < sz; k++) v[8*k +: 8] = ref_bytes[int'(addr) + k];
    if (f3 == 3'd0 && v[7])  v[31:8]  = 24'hFFFFFF;
    if (f3 == 3'd1 && v[15]) v[31:16] = 16'hFFFF;
    return v;
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
    int sz;
    logic legal, split, flt;
    logic [31:0] w0;
    sz    = size_of(f3);
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
    w0    = addr >> 2;
    split = (int'(addr % 4) + sz) > 4;
    flt   = !legal || (w0 >= 256) || (split && (w0 + 1 >= 256));
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    exp_we = we && !flt; exp_addr = w0; exp_stall = split && !flt;
    if (split && !flt) begin
      tick();
      exp_stall = 1'b0;
      exp_addr  = w0 + 1;
    end
    tick();
    exp_fault = flt;
    if (!flt) begin
      if (we) begin
        for (int k = 0; k < sz; k++) ref_bytes[int'(addr) + k] = wdata[8*k +: 8];
      end else begin
        exp_valid = 1'b1;
        exp_data  = model_load(addr, f3);
        exp_rd    = rd;
      end
    end
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    exp_we = 1'b0; exp_stall = 1'b0; exp_addr = 32'h0;
  endtask

  initial begin
    int diffs;
    logic [31:0] rw;
    total = 0; bad = 0; stall_cnt = 0; chk_en = 1'b0;
    for (int i = 0; i < 1024; i++) ref_bytes[i] = 8'h0;
    exp_stall = 0; exp_we = 0; exp_valid = 0; exp_fault = 0;
    exp_addr = 0; exp_data = 0; exp_rd = 0;
    pl_en = 1'b0; pl_idx = 8'h0; pl_data = 32'h0; clr = 1'b1;
    // Reset with a split store presented: nothing may leak out.
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h1A; req_wdata = 32'hDEADBEEF; req_rd = 5'd0;
    tick(); tick();
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_fault", 32'(resp_fault), 32'h0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_rd", 32'(resp_rd), 32'h0);
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    clr = 1'b0; rst_n = 1'b1; chk_en = 1'b1;
    tick();

    // Aligned word load.
    preload(5, 32'h8899AABB);
    s0 = stall_cnt;
    do_req(1'b0, 3'd2, 32'h14, 32'h0, 5'd3);
    check("lw_data", resp_data, 32'h8899AABB);
    check("lw_valid", 32'(resp_valid), 32'h1);
    tick();
    check("lw_nostall", 32'(stall_cnt - s0), 32'h0);

    // Sub-word store and byte loads.
    preload(5, 32'h11223344);
    do_req(1'b1, 3'd0, 32'h15, 32'h000000FF, 5'd0);
    tick();
    check("sb_word5", mem_tb[5], 32'h1122FF44);
    do_req(1'b0, 3'd0, 32'h15, 32'h0, 5'd4);
    check("lb_data", resp_data, 32'hFFFFFFFF);
    do_req(1'b0, 3'd4, 32'h15, 32'h0, 5'd5);
    check("lbu_data", resp_data, 32'h000000FF);
    tick();

    // Split halfword load.
    preload(2, 32'hAB000000);
    preload(3, 32'h000000CD);
    s0 = stall_cnt;
    do_req(1'b0, 3'd1, 32'h0B, 32'h0, 5'd6);
    check("lh_split_data", resp_data, 32'hFFFFCDAB);
    tick();
    check("lh_split_stall", 32'(stall_cnt - s0), 32'h1);

    // Split word store.
    s0 = stall_cnt;
    do_req(1'b1, 3'd2, 32'h1A, 32'hDEADBEEF, 5'd0);
    tick();
    check("sw_split_w6", mem_tb[6], 32'hBEEF0000);
    check("sw_split_w7", mem_tb[7], 32'h0000DEAD);
    check("sw_split_stall", 32'(stall_cnt - s0), 32'h1);

    // Faults.
    do_req(1'b0, 3'd2, 32'h400, 32'h0, 5'd8);
    check("flt_range", 32'(resp_fault), 32'h1);
    do_req(1'b0, 3'd3, 32'h30, 32'h0, 5'd9);
    check("flt_f3", 32'(resp_fault), 32'h1);
    do_req(1'b1, 3'd4, 32'h30, 32'h55, 5'd0);
    check("flt_sbu", 32'(resp_fault), 32'h1);
    do_req(1'b0, 3'd1, 32'h3FF, 32'h0, 5'd10);
    check("flt_split_end", 32'(resp_fault), 32'h1);
    do_req(1'b1, 3'd0, 32'h3FF, 32'h80, 5'd0);
    do_req(1'b0, 3'd0, 32'h3FF, 32'h0, 5'd11);
    check("lb_last_byte", resp_data, 32'hFFFFFF80);

    // Split word load on the splitting instance, fault on the other.
    preload(0, 32'h33221100);
    preload(1, 32'h77665544);
    do_req(1'b0, 3'd2, 32'h01, 32'h0, 5'd12);
    check("lw_split_data", resp_data, 32'h44332211);
    check("nomis_fault", 32'(resp_fault2), 32'h1);
    check("nomis_valid", 32'(resp_valid2), 32'h0);
    check("nomis_we", 32'(mem_we2), 32'h0);
    check("nomis_stall", 32'(stall2), 32'h0);
    check("nomis_addr", mem_addr2, 32'h0);
    check("nomis_wdata", mem_wdata2, 32'h0);
    check("nomis_data", resp_data2, 32'h0);

    // Back-to-back mix, including a split halfword store.
    do_req(1'b1, 3'd1, 32'h20, 32'h0000BEEF, 5'd0);
    do_req(1'b0, 3'd5, 32'h20, 32'h0, 5'd13);
    do_req(1'b0, 3'd1, 32'h20, 32'h0, 5'd14);
    do_req(1'b1, 3'd2, 32'h24, 32'h12345678, 5'd0);
    do_req(1'b0, 3'd2, 32'h24, 32'h0, 5'd15);
    do_req(1'b0, 3'd0, 32'h27, 32'h0, 5'd16);
    check("lb_b2b", resp_data, 32'h00000012);
    do_req(1'b1, 3'd1, 32'h27, 32'h0000A55A, 5'd0);
    do_req(1'b0, 3'd5, 32'h27, 32'h0, 5'd17);
    check("lhu_split", resp_data, 32'h0000A55A);
    do_req(1'b0, 3'd2, 32'h25, 32'h0, 5'd18);
    check("lw_split_mix", resp_data, 32'hA55A3456);
    do_req(1'b0, 3'd2, 32'h22, 32'h0, 5'd19);
    tick();

    // Reset during SECOND of a split load.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd1; req_addr = 32'h0B; req_rd = 5'd20;
    exp_we = 1'b0; exp_addr = 32'd2; exp_stall = 1'b1;
    tick();
    exp_stall = 1'b0; exp_addr = 32'h0;
    rst_n = 1'b0;
    #1;
    check("midrst_we", 32'(mem_we), 32'h0);
    check("midrst_addr", mem_addr, 32'h0);
    tick();
    exp_data = 32'h0; exp_rd = 5'd0;
    rst_n = 1'b1; req_valid = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_rd = 5'd0;
    check("midrst_valid", 32'(resp_valid), 32'h0);
    check("midrst_data", resp_data, 32'h0);
    tick();
    do_req(1'b0, 3'd2, 32'h14, 32'h0, 5'd21);
    check("post_rst_lw", resp_data, 32'h1122FF44);
    check("post_rst_rd", 32'(resp_rd), 32'd21);
    tick();
    tick();

    // Whole memory image against the model.
    diffs = 0;
    for (int w = 0; w < 256; w++) begin
      for (int k = 0; k < 4; k++) rw[8*k +: 8] = ref_bytes[4*w+k];
      if (mem_tb[w] !== rw) diffs++;
    end
    check("mem_image_diffs", 32'(diffs), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
